count_pwm_gen: RTL and testbench
================================

// Module: count_pwm_gen
// PURPOSE
//  Downstream consumer of the free-running 4-bit up-counter (sync_up). Turns the counter
//  value into a PWM waveform: the duty is loaded via a valid/ready handshake and double-buffered,
//  so changes take effect only at period boundaries. Also emits a period-start strobe and flags
//  counter sequence faults.
// PARAMETERS
//  CNT_W   4        width of the incoming counter value; period = 2**CNT_W cycles
//  DUTY_W  CNT_W+1  duty width; allows 0..2**CNT_W, i.e. 0%..100%
// PORTS
//  clk           in   1       clock, same domain as the counter
//  rst           in   1       reset rst, synchronous, active-high
//  en            in   1       enable; low forces the FSM to IDLE
//  count         in   CNT_W   counter value, expected +1 (mod 2**CNT_W) every clk
//  duty_in       in   DUTY_W  requested high-time, in counts
//  duty_valid    in   1       duty_in is valid
//  duty_ready    out  1       pending slot empty; transfer happens on valid&&ready
//  pwm_out       out  1       PWM output, registered
//  period_start  out  1       1-cycle pulse, registered, when count==0 is seen in RUN
//  seq_err       out  1       sticky: count failed to increment by exactly 1 while in RUN
// BEHAVIOUR
//  Reset values: pwm_out=0, period_start=0, seq_err=0, duty_ready=1, state=IDLE,
//   active_duty=0, pending empty, prev_count=0.
//  FSM:
//   IDLE: entered on rst or !en (from any state). Outputs pwm_out=0, period_start=0.
//     Go to SYNC when en=1.
//   SYNC: wait for alignment; pwm_out=0. When count==0, go to RUN in the same edge; that
//     edge is treated as a period boundary.
//   RUN: pwm_out <= (count < active_duty) (1-cycle latency from count).
//     period_start <= (count==0).
//  Handshake: duty_ready = !pending_valid. On the clk edge where duty_valid && duty_ready,
//   pending <= min(duty_in, 2**CNT_W) and pending_valid <= 1. duty_valid with ready=0 is
//   ignored; the source must hold the value.
//  Period boundary (SYNC->RUN edge, or RUN with count==0): if pending_valid, then
//   active_duty <= pending and pending_valid <= 0. The duty compare for that same edge
//   uses the new value, so the new period is entirely at the new duty. A duty accepted on a
//   boundary edge is applied at the next boundary, not at this one.
//  Duty extremes: 0 -> pwm_out constantly 0. >= 2**CNT_W -> pwm_out constantly 1 in RUN
//   (no glitch at wrap).
//  Sequence check (RUN only, excluding the SYNC->RUN edge): when
//   count != prev_count+1 (mod 2**CNT_W), seq_err <= 1. seq_err holds until rst;
//   prev_count <= count every clk.
//  Wrap: CNT_W-bit add discards the carry, so 15->0 is legal. A held count (e.g. upstream
//   reset) in RUN sets seq_err.
//  en drop mid-period: next edge -> IDLE, pwm_out=0; active_duty is kept; pending is kept.
//  rst mid-operation: all state returns to reset values on that edge.
//  Simultaneous rst and duty_valid: rst wins; nothing is accepted.
// STRUCTURE
//  Shared package cnt_pkg: CNT_W default, state enum {IDLE, SYNC, RUN} with 2-bit encoding,
//   and function sat_duty().
//  One natural sub-module: duty_shadow_reg (pending/active double buffer with valid/ready).
//   The FSM, compare and sequence checker stay in the top level.
// TESTING
//  1 rst high 3 clk, counter free-running -> pwm_out=0, duty_ready=1, seq_err=0,
//    period_start=0.
//  2 en=1, load duty=4 before count==0 -> SYNC->RUN at count 0; each period: pwm_out high
//    for 4 clk, low for 12; period_start pulses once per 16 clk.
//  3 Load duty=10 when count=7 -> current period stays at 4; next period is 10 high/6 low;
//    duty_ready is low from acceptance until the boundary.
//  4 duty=0, then duty=20 -> pwm_out all 0; then pwm_out all 1 (clamped to 16), with no
//    low cycle at the 15->0 wrap.
//  5 In RUN, force count 5->9 -> seq_err=1 next clk and stays 1; a later rst clears it.
//  6 Drop en at count=2 -> next clk IDLE, pwm_out=0. Re-raise en -> waits for count==0,
//    then resumes at the previous active duty.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared definitions for blocks that consume the free-running up-counter.
package cnt_pkg;

   localparam int unsigned CNT_W_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Clamp a requested duty to the full period length (2**cnt_w counts).
   function automatic logic [31:0] sat_duty(input logic [31:0] duty, input int unsigned cnt_w);
      logic [31:0] full;
      full = 32'd1 << cnt_w;
      return (duty > full) ? full : duty;
   endfunction

endpackage

// File: rtl/duty_shadow_reg.sv
// Double-buffered duty register: a pending slot filled through valid/ready,
// promoted to the active duty only on a period boundary.
module duty_shadow_reg
   import cnt_pkg::*;
#(
   parameter int unsigned CNT_W  = CNT_W_DEFAULT,
   parameter int unsigned DUTY_W = CNT_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] duty_in,
   input  logic              duty_valid,
   output logic              duty_ready,
   input  logic              boundary,
   output logic [DUTY_W-1:0] cmp_duty
);

   logic [DUTY_W-1:0] pending;
   logic              pending_valid;
   logic [DUTY_W-1:0] active_duty;
   logic [DUTY_W-1:0] duty_sat;
   logic              accept;

   assign duty_ready = !pending_valid;
   assign accept     = duty_valid && !pending_valid;
   assign duty_sat   = DUTY_W'(sat_duty(32'(duty_in), CNT_W));

   // The compare on a boundary edge already sees the duty being promoted,
   // so a new period starts cleanly at the new duty.
   always_comb begin
      cmp_duty = active_duty;
      if (boundary && pending_valid) begin
         cmp_duty = pending;
      end
   end

   // Pending/active update; accept and promote are exclusive because
   // accept needs an empty slot and promote needs a full one.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending       <= '0;
         pending_valid <= 1'b0;
         active_duty   <= '0;
      end else if (boundary && pending_valid) begin
         active_duty   <= pending;
         pending_valid <= 1'b0;
      end else if (accept) begin
         pending       <= duty_sat;
         pending_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external free-running up-counter. Aligns to
// count==0, produces a period-start strobe and flags counter sequence faults.
module count_pwm_gen
   import cnt_pkg::*;
#(
   parameter int unsigned CNT_W  = CNT_W_DEFAULT,
   parameter int unsigned DUTY_W = CNT_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [CNT_W-1:0]  count,
   input  logic [DUTY_W-1:0] duty_in,
   input  logic              duty_valid,
   output logic              duty_ready,
   output logic              pwm_out,
   output logic              period_start,
   output logic              seq_err
);

   state_t            state;
   logic [CNT_W-1:0]  prev_count;
   logic [CNT_W-1:0]  prev_inc;
   logic [DUTY_W-1:0] cmp_duty;
   logic              cnt_zero;
   logic              boundary;
   logic              duty_hit;

   assign cnt_zero = (count == '0);
   assign prev_inc = prev_count + CNT_W'(1);
   assign duty_hit = (DUTY_W'(count) < cmp_duty);
   // The SYNC->RUN edge counts as a boundary just like count==0 in RUN.
   assign boundary = en && cnt_zero && ((state == SYNC) || (state == RUN));

   duty_shadow_reg #(
      .CNT_W  (CNT_W),
      .DUTY_W (DUTY_W)
   ) u_duty_shadow (
      .clk        (clk),
      .rst        (rst),
      .duty_in    (duty_in),
      .duty_valid (duty_valid),
      .duty_ready (duty_ready),
      .boundary   (boundary),
      .cmp_duty   (cmp_duty)
   );

   // Mode FSM with registered PWM, period strobe and sticky sequence check.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
         seq_err      <= 1'b0;
         prev_count   <= '0;
      end else begin
         prev_count <= count;
         if (!en) begin
            state        <= IDLE;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  state        <= SYNC;
                  pwm_out      <= 1'b0;
                  period_start <= 1'b0;
               end
               SYNC: begin
                  // Alignment edge already produces the first RUN output so
                  // the opening period is complete.
                  if (cnt_zero) begin
                     state        <= RUN;
                     pwm_out      <= duty_hit;
                     period_start <= 1'b1;
                  end else begin
                     pwm_out      <= 1'b0;
                     period_start <= 1'b0;
                  end
               end
               RUN: begin
                  pwm_out      <= duty_hit;
                  period_start <= cnt_zero;
                  if (count != prev_inc) begin
                     seq_err <= 1'b1;
                  end
               end
               default: begin
                  state        <= IDLE;
                  pwm_out      <= 1'b0;
                  period_start <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_count_pwm_gen.sv
// Scoreboard bench for count_pwm_gen: the stimulus pushes the hand-derived
// post-edge outputs; a monitor pops and compares on the falling edge.
module tb_count_pwm_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] count;
   logic [4:0] duty_in;
   logic       duty_valid;
   logic       duty_ready;
   logic       pwm_out;
   logic       period_start;
   logic       seq_err;

   always #5 clk = ~clk;

   count_pwm_gen #(
      .CNT_W  (4),
      .DUTY_W (5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .count        (count),
      .duty_in      (duty_in),
      .duty_valid   (duty_valid),
      .duty_ready   (duty_ready),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .seq_err      (seq_err)
   );

   typedef struct {
      string       name;
      logic [3:0]  exp;   // {pwm_out, period_start, seq_err, duty_ready}
      int unsigned c;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned c = 0;

   // Drive count=c for one edge and queue the outputs expected after it.
   task automatic tick(input string name, input logic p, input logic ps,
                       input logic err, input logic rdy);
      exp_t e;
      count = 4'(c);
      @(posedge clk);
      e.name = name;
      e.exp  = {p, ps, err, rdy};
      e.c    = c;
      sb.push_back(e);
      #1;
      c = (c + 1) % 16;
   endtask

   // Steady RUN periods: high while count < duty, strobe on count 0.
   task automatic run(input int n, input int unsigned duty, input logic err,
                      input logic rdy, input string name);
      for (int i = 0; i < n; i++) begin
         tick(name, (c < duty), (c == 0), err, rdy);
      end
   endtask

   // Monitor: compare every queued expectation mid-cycle.
   always @(negedge clk) begin
      exp_t       e;
      logic [3:0] got;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         got = {pwm_out, period_start, seq_err, duty_ready};
         tests++;
         if (got !== e.exp) begin
            fails++;
            $display("FAIL %s count=%0d pwm/ps/err/rdy got=%b exp=%b",
                     e.name, e.c, got, e.exp);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; en = 1'b0; duty_valid = 1'b0; duty_in = '0; count = '0;

      // Reset with the counter running
      for (int i = 0; i < 3; i++) tick("reset", 1'b0, 1'b0, 1'b0, 1'b1);

      // Enable and load duty 4 before alignment
      rst = 1'b0; en = 1'b1; duty_in = 5'd4; duty_valid = 1'b1;
      tick("sync_accept", 1'b0, 1'b0, 1'b0, 1'b0);
      duty_valid = 1'b0;
      for (int i = 0; i < 12; i++) tick("sync_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      run(32, 4, 1'b0, 1'b1, "duty4");

      // Load 10 mid-period: applies at the next boundary
      run(7, 4, 1'b0, 1'b1, "duty4_pre");
      duty_in = 5'd10; duty_valid = 1'b1;
      tick("accept10", 1'b0, 1'b0, 1'b0, 1'b0);
      duty_valid = 1'b0;
      run(8, 4, 1'b0, 1'b0, "duty4_hold");
      run(16, 10, 1'b0, 1'b1, "duty10");

      // Drop enable at count 2, re-enable and resume at duty 10
      run(2, 10, 1'b0, 1'b1, "pre_drop");
      en = 1'b0;
      tick("en_drop", 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick("idle", 1'b0, 1'b0, 1'b0, 1'b1);
      en = 1'b1;
      tick("resync", 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) tick("sync2", 1'b0, 1'b0, 1'b0, 1'b1);
      run(16, 10, 1'b0, 1'b1, "resume10");

      // Duty 0 accepted on a boundary edge takes effect one period later
      duty_in = 5'd0; duty_valid = 1'b1;
      tick("accept_on_boundary", 1'b1, 1'b1, 1'b0, 1'b0);
      duty_valid = 1'b0;
      run(15, 10, 1'b0, 1'b0, "hold10");
      run(5, 0, 1'b0, 1'b1, "duty0");
      duty_in = 5'd20; duty_valid = 1'b1;
      tick("accept20", 1'b0, 1'b0, 1'b0, 1'b0);
      duty_valid = 1'b0;
      run(10, 0, 1'b0, 1'b0, "duty0_hold");
      run(32, 16, 1'b0, 1'b1, "duty16_clamped");

      // Counter jump 5 -> 9 in RUN sets a sticky error
      run(6, 16, 1'b0, 1'b1, "pre_jump");
      c = 9;
      tick("jump", 1'b1, 1'b0, 1'b1, 1'b1);
      run(4, 16, 1'b1, 1'b1, "err_sticky");

      // Reset wins over a simultaneous duty offer
      rst = 1'b1; duty_in = 5'd7; duty_valid = 1'b1;
      tick("rst_wins", 1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0; duty_valid = 1'b0;
      tick("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
